rr_arbiter4_v: RTL and testbench

- 4-requester round-robin arbiter with registered one-hot grants.
- Where a 4-input OR reduction collapses requests into one "any request" line, this block is the responder: it answers those requests and drives one grant back to each requester.
- Sits between four datapath masters and a shared resource, such as a bus or register-file write port.

---
 rtl/rr_arbiter4_v.sv | 124 ++++++++++++
 tb/tb_rr_arbiter4_v.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter4_v.sv
// 4-requester round-robin arbiter with registered one-hot grants, hold limit and a one-cycle gap after every release.
// Optional grant counter output o_gnt_cnt is enabled by defining RR_ARB_GNT_COUNT_EN.
module rr_arbiter4_v #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 8
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [3:0] i_req,
  output logic [3:0] o_gnt,
  output logic [1:0] o_gnt_id,
  output logic       o_busy,
  output logic       o_timeout
`ifdef RR_ARB_GNT_COUNT_EN
  ,
  output logic [7:0] o_gnt_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);

  state_t           state, state_nxt;
  logic [1:0]       ptr, ptr_nxt;
  logic [1:0]       id_nxt;
  logic [CNT_W-1:0] hold, hold_nxt;
  logic [3:0]       gnt_nxt;
  logic             tmo_nxt;
  logic [2:0]       pick;
  logic             grant_start;

  // Returns {found, index} of the first request at or after base, wrapping mod 4.
  function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] base);
    logic [2:0] r;
    logic [1:0] idx;
    r = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      idx = base + 2'(k);
      if (req[idx]) r = {1'b1, idx};
    end
    return r;
  endfunction

  function automatic logic [3:0] onehot(input logic [1:0] id);
    return 4'b0001 << id;
  endfunction

  assign pick        = rr_pick(i_req, ptr);
  assign grant_start = (state == IDLE) && pick[2];
  assign o_busy      = |o_gnt;

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    id_nxt    = o_gnt_id;
    hold_nxt  = hold;
    gnt_nxt   = o_gnt;
    tmo_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (pick[2]) begin
          gnt_nxt   = onehot(pick[1:0]);
          id_nxt    = pick[1:0];
          ptr_nxt   = pick[1:0] + 2'd1;
          hold_nxt  = CNT_W'(1);
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        if (!i_req[o_gnt_id]) begin
          gnt_nxt   = 4'b0000;
          hold_nxt  = '0;
          state_nxt = GAP;
        end else if (hold >= HOLD_MAX) begin
          // Owner still requesting at the limit: revoke and flag it.
          gnt_nxt   = 4'b0000;
          hold_nxt  = '0;
          tmo_nxt   = 1'b1;
          state_nxt = GAP;
        end else begin
          hold_nxt  = hold + CNT_W'(1);
        end
      end
      GAP: begin
        state_nxt = IDLE;
      end
      default: begin
        gnt_nxt   = 4'b0000;
        hold_nxt  = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= IDLE;
      ptr       <= 2'd0;
      hold      <= '0;
      o_gnt     <= 4'b0000;
      o_gnt_id  <= 2'd0;
      o_timeout <= 1'b0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      hold      <= hold_nxt;
      o_gnt     <= gnt_nxt;
      o_gnt_id  <= id_nxt;
      o_timeout <= tmo_nxt;
    end
  end

`ifdef RR_ARB_GNT_COUNT_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_gnt_cnt <= 8'h00;
    end else if (grant_start && (o_gnt_cnt != 8'hFF)) begin
      o_gnt_cnt <= o_gnt_cnt + 8'h01;
    end
  end
`endif

endmodule

// File: tb/tb_rr_arbiter4_v.sv
// Scoreboarded randomized bench for rr_arbiter4_v against a cycle-level behavioural model.
module tb_rr_arbiter4_v;
  localparam int MAX_HOLD = 8;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic [3:0] i_req = 4'b0000;
  logic [3:0] o_gnt;
  logic [1:0] o_gnt_id;
  logic       o_busy;
  logic       o_timeout;
`ifdef RR_ARB_GNT_COUNT_EN
  logic [7:0] o_gnt_cnt;
`endif

  rr_arbiter4_v #(.MAX_HOLD(MAX_HOLD), .CNT_W(8)) dut (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .i_req(i_req),
    .o_gnt(o_gnt),
    .o_gnt_id(o_gnt_id),
    .o_busy(o_busy),
    .o_timeout(o_timeout)
`ifdef RR_ARB_GNT_COUNT_EN
    ,
    .o_gnt_cnt(o_gnt_cnt)
`endif
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [3:0] gnt;
    logic [1:0] id;
    logic       busy;
    logic       tmo;
    logic [7:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: who owns the grant, how long they have held it, whether a dead cycle is pending.
  int   owner = -1;
  int   mptr  = 0;
  int   held  = 0;
  int   cool  = 0;
  int   mcnt  = 0;
  logic mtmo  = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model(input logic rst, input logic [3:0] req);
    int c;
    mtmo = 1'b0;
    if (rst) begin
      owner = -1; mptr = 0; held = 0; cool = 0; mcnt = 0;
    end else if (owner >= 0) begin
      if (!req[owner]) begin
        owner = -1; cool = 1;
      end else if (held >= MAX_HOLD) begin
        owner = -1; cool = 1; mtmo = 1'b1;
      end else begin
        held++;
      end
    end else if (cool != 0) begin
      cool = 0;
    end else if (req != 4'b0000) begin
      for (int k = 0; k < 4; k++) begin
        c = (mptr + k) % 4;
        if (req[c]) begin
          owner = c;
          mptr  = (c + 1) % 4;
          held  = 1;
          if (mcnt < 255) mcnt++;
          break;
        end
      end
    end
  endtask

  // Drive one cycle of stimulus, push the expected post-edge response, return after the edge.
  task automatic step(input logic rst, input logic [3:0] req);
    exp_t e;
    @(negedge i_clk);
    i_rst = rst;
    i_req = req;
    model(rst, req);
    e.gnt  = (owner >= 0) ? (4'b0001 << owner) : 4'b0000;
    e.id   = (owner >= 0) ? 2'(owner) : 2'd0;
    e.busy = (owner >= 0);
    e.tmo  = mtmo;
    e.cnt  = 8'(mcnt);
    sb.push_back(e);
    @(posedge i_clk);
    #2;
  endtask

  // Monitor: every cycle the DUT presents a fresh registered response.
  initial begin
    exp_t e;
    forever begin
      @(posedge i_clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("gnt", int'(o_gnt), int'(e.gnt));
        chk("busy", int'(o_busy), int'(e.busy));
        chk("timeout", int'(o_timeout), int'(e.tmo));
        chk("onehot0", int'($onehot0(o_gnt)), 1);
        if (e.busy) chk("gnt_id", int'(o_gnt_id), int'(e.id));
`ifdef RR_ARB_GNT_COUNT_EN
        chk("gnt_cnt", int'(o_gnt_cnt), int'(e.cnt));
`endif
      end
    end
  end

  initial begin
    logic [3:0] req;
    logic [3:0] prev;
    int         starts[$];
    int         run, first_run, tmo_seen;
    logic       rst;

    // Reset held for two cycles with every requester active.
    step(1'b1, 4'b1111);
    chk("rst_gnt", int'(o_gnt), 0);
    step(1'b1, 4'b1111);
    chk("rst_gnt2", int'(o_gnt), 0);
    chk("rst_tmo", int'(o_timeout), 0);
    step(1'b0, 4'b1111);
    chk("first_gnt", int'(o_gnt), 1);

    // Rotation: the owner drops its request after three grant cycles.
    prev = o_gnt;
    starts.push_back(int'(o_gnt));
    for (int i = 0; i < 80 && starts.size() < 5; i++) begin
      req = 4'b1111;
      if (owner >= 0 && held == 3) req[owner] = 1'b0;
      step(1'b0, req);
      if (o_gnt != 4'b0000 && prev == 4'b0000) starts.push_back(int'(o_gnt));
      prev = o_gnt;
    end
    chk("rot_count", starts.size(), 5);
    if (starts.size() == 5) begin
      chk("rot0", starts[0], 1);
      chk("rot1", starts[1], 2);
      chk("rot2", starts[2], 4);
      chk("rot3", starts[3], 8);
      chk("rot4", starts[4], 1);
    end

    // Timeout with a single requester held high.
    step(1'b1, 4'b0000);
    run = 0; first_run = -1; tmo_seen = 0;
    for (int i = 0; i < 30; i++) begin
      step(1'b0, 4'b0100);
      if (o_gnt == 4'b0100) run++;
      else begin
        if (run > 0 && first_run < 0) first_run = run;
        run = 0;
      end
      if (o_timeout && o_gnt == 4'b0000) tmo_seen++;
    end
    chk("tmo_hold_len", first_run, MAX_HOLD);
    chk("tmo_pulses", int'(tmo_seen > 0), 1);

    // Pointer skip: after granting 0, requesters 0 and 3 compete.
    step(1'b1, 4'b0000);
    step(1'b0, 4'b0001);
    chk("skip_g0", int'(o_gnt), 1);
    step(1'b0, 4'b0000);
    step(1'b0, 4'b0000);
    step(1'b0, 4'b1001);
    chk("skip_g3", int'(o_gnt), 8);
    step(1'b0, 4'b0000);
    step(1'b0, 4'b0000);
    step(1'b0, 4'b1111);
    chk("skip_wrap", int'(o_gnt), 1);

    // Reset while requester 1 holds the grant at count 3.
    step(1'b1, 4'b0000);
    step(1'b0, 4'b1111);
    step(1'b0, 4'b1110);
    step(1'b0, 4'b1110);
    step(1'b0, 4'b1110);
    chk("mid_g1", int'(o_gnt), 2);
    step(1'b0, 4'b1110);
    step(1'b0, 4'b1110);
    step(1'b1, 4'b1110);
    chk("mid_rst_gnt", int'(o_gnt), 0);
    chk("mid_rst_tmo", int'(o_timeout), 0);
    step(1'b0, 4'b1111);
    chk("mid_ptr0", int'(o_gnt), 1);

    // Randomized traffic with occasional resets.
    req = 4'b0000;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 1) == 0) req = 4'($urandom_range(0, 15));
      rst = ($urandom_range(0, 39) == 0);
      step(rst, req);
    end

`ifdef RR_ARB_GNT_COUNT_EN
    // Grant counter saturation: one short grant every three cycles.
    step(1'b1, 4'b0000);
    for (int i = 0; i < 950; i++) begin
      req = (owner >= 0) ? 4'b0000 : 4'($urandom_range(1, 15));
      step(1'b0, req);
    end
    chk("cnt_sat", int'(o_gnt_cnt), 255);
    step(1'b1, 4'b0000);
    chk("cnt_clr", int'(o_gnt_cnt), 0);
`endif

    step(1'b0, 4'b0000);
    repeat (3) @(posedge i_clk);
    #3;
    chk("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
